// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: a control field and a payload move between two stages over valid/ready.
// It adds an optional skid entry, stall bubbles, flush, kill-bit masking and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int                DATA_W    = 96,
  parameter int                CTRL_W    = 16,
  parameter logic [CTRL_W-1:0] KILL_MASK = 'h7,
  parameter bit                SKID      = 1'b1,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Handshake: a word moves on any edge where valid and ready are both high.
  // Once a word is offered, valid holds until it is taken.
  logic              r_m_v;
  logic              r_s_v;
  logic              r_reset_q;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic [DATA_W-1:0] r_s_data;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic              w_in_xfer;
  logic              w_main_free;

  assign w_main_free = !r_m_v || out_ready;
  // With the skid entry, in_ready comes only from registers, so out_ready has no combinational path to it.
  assign in_ready    = (SKID ? !r_s_v : w_main_free) && !stall && !reset && !r_reset_q;
  assign w_in_xfer   = in_valid && in_ready;

  assign out_valid  = r_m_v;
  assign out_data   = r_m_data;
  assign out_ctrl   = r_m_v ? r_m_ctrl : (r_m_ctrl & ~KILL_MASK);
  assign bubble_cnt = r_bubble_cnt;

  always_ff @(posedge clk) begin
    r_reset_q <= reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_v    <= 1'b0;
      r_s_v    <= 1'b0;
      r_m_ctrl <= '0;
      r_s_ctrl <= '0;
      r_m_data <= '0;
      r_s_data <= '0;
    end else if (flush) begin
      // Data registers keep their contents. Only valids and control are cleared.
      r_m_v    <= 1'b0;
      r_s_v    <= 1'b0;
      r_m_ctrl <= '0;
      r_s_ctrl <= '0;
    end else if (SKID) begin
      if (w_main_free) begin
        if (r_s_v) begin
          r_m_v    <= 1'b1;
          r_m_ctrl <= r_s_ctrl;
          r_m_data <= r_s_data;
          r_s_v    <= 1'b0;
        end else begin
          r_m_v    <= w_in_xfer;
          r_m_ctrl <= in_ctrl;
          r_m_data <= in_data;
        end
      end else if (w_in_xfer) begin
        r_s_v    <= 1'b1;
        r_s_ctrl <= in_ctrl;
        r_s_data <= in_data;
      end
    end else if (w_main_free) begin
      r_m_v    <= w_in_xfer;
      r_m_ctrl <= in_ctrl;
      r_m_data <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (!r_m_v && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance (default widths) and a single-entry instance with a 4-bit counter.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset, in_valid, in_ready, stall, flush, out_valid, out_ready;
  logic [15:0] in_ctrl, out_ctrl, bubble_cnt;
  logic [95:0] in_data, out_data;

  logic       reset2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [7:0] in_ctrl2, out_ctrl2, in_data2, out_data2;
  logic [3:0] bubble_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(8), .CTRL_W(8), .KILL_MASK(8'h07), .SKID(1'b0), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_ctrl(in_ctrl2), .in_data(in_data2), .stall(1'b0), .flush(1'b0),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_ctrl(out_ctrl2),
    .out_data(out_data2), .bubble_cnt(bubble_cnt2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [95:0] d, input logic [15:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; out_ready = 0; drive(0, 0, 0);
    reset2 = 1; in_valid2 = 0; in_ctrl2 = 0; in_data2 = 0; out_ready2 = 0;
    repeat (2) cyc();
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ctrl", out_ctrl, 0);
    check("rst_cnt", bubble_cnt, 0);
    check("rst_ready", in_ready, 0);
    reset = 0;
    #1 check("ready_after_rst", in_ready, 0);
    cyc();
    #1 check("ready_up", in_ready, 1);
    check("cnt_first", bubble_cnt, 1);

    // stream of four words
    out_ready = 1;
    drive(1, 1, 16'h0007);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) drive(1, 96'(i + 1), 16'h0007);
      else drive(0, 0, 0);
      #1;
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, 128'(i));
      check("stream_ctrl", out_ctrl, 16'h0007);
      check("stream_cnt", bubble_cnt, 2);
      cyc();
    end

    // skid: A in main, B to skid, C held upstream
    out_ready = 0;
    drive(1, 'hA, 16'h0007);
    #1 check("pre_a_valid", out_valid, 0);
    check("pre_a_ready", in_ready, 1);
    cyc();
    drive(1, 'hB, 16'h0007);
    #1 check("a_held", out_data, 'hA);
    check("skid_room", in_ready, 1);
    cyc();
    drive(1, 'hC, 16'h0007);
    #1 check("skid_full_ready", in_ready, 0);
    check("a_still", out_data, 'hA);
    cyc();
    #1 check("skid_full_ready2", in_ready, 0);
    out_ready = 1;
    #1 check("ready_registered", in_ready, 0);
    cyc();
    #1 check("b_valid", out_valid, 1);
    check("b_data", out_data, 'hB);
    check("skid_drained_ready", in_ready, 1);
    cyc();
    drive(0, 0, 0);
    #1 check("c_valid", out_valid, 1);
    check("c_data", out_data, 'hC);
    cyc();

    // two-cycle stall mid-stream
    drive(1, 'h11, 16'h0007);
    #1 check("post_c_empty", out_valid, 0);
    cyc();
    drive(1, 'h12, 16'h0007);
    #1 check("w11", out_data, 'h11);
    check("cnt_before_stall", bubble_cnt, 4);
    cyc();
    drive(1, 'h13, 16'h0007);
    stall = 1;
    #1 check("w12", out_data, 'h12);
    check("stall_ready", in_ready, 0);
    cyc();
    #1 check("bubble1_valid", out_valid, 0);
    check("bubble1_ctrl", out_ctrl, 0);
    cyc();
    stall = 0;
    #1 check("bubble2_valid", out_valid, 0);
    check("bubble2_ctrl", out_ctrl, 0);
    check("bubble2_cnt", bubble_cnt, 5);
    check("unstall_ready", in_ready, 1);
    cyc();
    drive(1, 'h14, 16'h0007);
    #1 check("w13_valid", out_valid, 1);
    check("w13", out_data, 'h13);
    check("cnt_after_stall", bubble_cnt, 6);
    cyc();
    drive(0, 0, 0);
    #1 check("w14", out_data, 'h14);
    cyc();

    // flush with main and skid full, then flush with an accepted input
    out_ready = 0;
    drive(1, 'h21, 16'h0007);
    #1 check("pre_21_empty", out_valid, 0);
    cyc();
    drive(1, 'h22, 16'h0007);
    #1 check("w21", out_data, 'h21);
    cyc();
    drive(1, 'h23, 16'h0007);
    flush = 1;
    #1 check("flush_skid_full", in_ready, 0);
    cyc();
    flush = 0;
    out_ready = 1;
    drive(1, 'h24, 16'h0007);
    #1 check("flush_valid", out_valid, 0);
    check("flush_ctrl", out_ctrl, 0);
    check("flush_ready", in_ready, 1);
    cyc();
    drive(1, 'h25, 16'h0007);
    flush = 1;
    #1 check("w24_valid", out_valid, 1);
    check("w24", out_data, 'h24);
    check("flush2_ready", in_ready, 1);
    cyc();
    flush = 0;
    drive(1, 'h26, 16'h0007);
    #1 check("flush2_valid", out_valid, 0);
    check("flush2_ctrl", out_ctrl, 0);
    cyc();
    drive(0, 0, 0);
    #1 check("w26_valid", out_valid, 1);
    check("w26", out_data, 'h26);
    cyc();

    // reset with both entries full
    out_ready = 0;
    drive(1, 'h31, 16'h0007);
    cyc();
    drive(1, 'h32, 16'h0007);
    cyc();
    drive(0, 0, 0);
    #1 check("w31", out_data, 'h31);
    check("full_ready", in_ready, 0);
    reset = 1;
    #1 check("in_rst_ready", in_ready, 0);
    cyc();
    reset = 0;
    #1 check("rst2_valid", out_valid, 0);
    check("rst2_ctrl", out_ctrl, 0);
    check("rst2_cnt", bubble_cnt, 0);
    check("rst2_ready", in_ready, 0);
    out_ready = 1;
    cyc();
    #1 check("rst2_ready_up", in_ready, 1);
    check("rst2_no_stale", out_valid, 0);
    check("rst2_cnt1", bubble_cnt, 1);

    // single-entry instance: counter saturation and combinational in_ready
    check("d2_rst_valid", out_valid2, 0);
    check("d2_rst_cnt", bubble_cnt2, 0);
    check("d2_rst_ready", in_ready2, 0);
    reset2 = 0;
    #1 check("d2_ready_after_rst", in_ready2, 0);
    cyc();
    repeat (4) cyc();
    #1 check("d2_cnt5", bubble_cnt2, 5);
    repeat (15) cyc();
    #1 check("d2_cnt_sat", bubble_cnt2, 15);
    repeat (3) cyc();
    #1 check("d2_cnt_hold", bubble_cnt2, 15);
    in_valid2 = 1; in_data2 = 8'h5A; in_ctrl2 = 8'hFF;
    #1 check("d2_ready_empty", in_ready2, 1);
    cyc();
    in_data2 = 8'h5B;
    #1 check("d2_valid", out_valid2, 1);
    check("d2_data", out_data2, 8'h5A);
    check("d2_ctrl", out_ctrl2, 8'hFF);
    check("d2_ready_blocked", in_ready2, 0);
    out_ready2 = 1;
    #1 check("d2_ready_comb", in_ready2, 1);
    cyc();
    in_valid2 = 0; in_data2 = 0; in_ctrl2 = 0;
    #1 check("d2_data2", out_data2, 8'h5B);
    cyc();
    #1 check("d2_drained", out_valid2, 0);
    check("d2_kill_bits", out_ctrl2 & 8'h07, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
